// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage plus 32 x 32-bit integer register file.
// Load-data extension, final writeback mux, register storage with two
// combinational read ports, and a count of committed register writes.
// Optional feature: define WB_REGFILE_BYPASS_EN to make a same-cycle write
// visible on the read ports (write-through). Without it, reads return stored
// contents only.
//
// Handshake: none. Every cycle is one commit opportunity; a commit happens
// when RST=1, WB_WRITE_ENABLE=1 and WB_RD!=0, and it is never back-pressured.
module wb_regfile (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] WB_JAL_SELECTED,
  input  logic [31:0] WB_DATA_OUT,
  input  logic [4:0]  WB_RD,
  input  logic        WB_WRITE_ENABLE,
  input  logic        WB_DATA_MEM_SELECT,
  input  logic [2:0]  WB_FUNC3,
  input  logic [4:0]  RS1_ADDR,
  input  logic [4:0]  RS2_ADDR,
  output logic [31:0] RS1_DATA,
  output logic [31:0] RS2_DATA,
  output logic [31:0] WB_RESULT,
  output logic [31:0] RETIRE_COUNT
);

  // Entry 0 is never written (commit requires WB_RD != 0) so it holds 0.
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] retire_count_q;
  logic [31:0] retire_count_d;
  logic [31:0] load_ext;
  logic        commit;

  // Extend right-aligned load data according to the load width/sign code.
  always_comb begin
    load_ext = WB_DATA_OUT;
    case (WB_FUNC3)
      3'b000:  load_ext = {{24{WB_DATA_OUT[7]}}, WB_DATA_OUT[7:0]};
      3'b001:  load_ext = {{16{WB_DATA_OUT[15]}}, WB_DATA_OUT[15:0]};
      3'b100:  load_ext = {24'd0, WB_DATA_OUT[7:0]};
      3'b101:  load_ext = {16'd0, WB_DATA_OUT[15:0]};
      default: load_ext = WB_DATA_OUT;
    endcase
  end

  // Final writeback value; also feeds the forwarding unit.
  always_comb begin
    WB_RESULT = WB_DATA_MEM_SELECT ? load_ext : WB_JAL_SELECTED;
  end

  // A commit needs reset released, a write request and a non-x0 target.
  always_comb begin
    commit = RST && WB_WRITE_ENABLE && (WB_RD != 5'd0);
  end

  // Next register-file contents and retire count.
  always_comb begin
    regs_d         = regs_q;
    retire_count_d = retire_count_q;
    if (commit) begin
      regs_d[WB_RD]  = WB_RESULT;
      retire_count_d = retire_count_q + 32'd1;
    end
  end

  // Storage; reset clears everything immediately without a clock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      retire_count_q <= 32'd0;
    end else begin
      regs_q         <= regs_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Combinational read ports; x0 always reads zero.
  always_comb begin
    RS1_DATA = (RS1_ADDR == 5'd0) ? 32'd0 : regs_q[RS1_ADDR];
    RS2_DATA = (RS2_ADDR == 5'd0) ? 32'd0 : regs_q[RS2_ADDR];
`ifdef WB_REGFILE_BYPASS_EN
    if (commit && (WB_RD == RS1_ADDR)) RS1_DATA = WB_RESULT;
    if (commit && (WB_RD == RS2_ADDR)) RS2_DATA = WB_RESULT;
`else
`endif
  end

  // Counter wraps naturally at 2^32.
  always_comb begin
    RETIRE_COUNT = retire_count_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vectors with hand-computed values, plus a
// behavioural model compared against every output at each falling clock edge.
module tb_wb_regfile;

  logic        CLK;
  logic        RST;
  logic [31:0] WB_JAL_SELECTED;
  logic [31:0] WB_DATA_OUT;
  logic [4:0]  WB_RD;
  logic        WB_WRITE_ENABLE;
  logic        WB_DATA_MEM_SELECT;
  logic [2:0]  WB_FUNC3;
  logic [4:0]  RS1_ADDR;
  logic [4:0]  RS2_ADDR;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic [31:0] WB_RESULT;
  logic [31:0] RETIRE_COUNT;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  bit          cmp_on;

  wb_regfile dut (
    .CLK                (CLK),
    .RST                (RST),
    .WB_JAL_SELECTED    (WB_JAL_SELECTED),
    .WB_DATA_OUT        (WB_DATA_OUT),
    .WB_RD              (WB_RD),
    .WB_WRITE_ENABLE    (WB_WRITE_ENABLE),
    .WB_DATA_MEM_SELECT (WB_DATA_MEM_SELECT),
    .WB_FUNC3           (WB_FUNC3),
    .RS1_ADDR           (RS1_ADDR),
    .RS2_ADDR           (RS2_ADDR),
    .RS1_DATA           (RS1_DATA),
    .RS2_DATA           (RS2_DATA),
    .WB_RESULT          (WB_RESULT),
    .RETIRE_COUNT       (RETIRE_COUNT)
  );

  // Clock block.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: value a load/ALU writeback should produce.
  function automatic logic [31:0] m_result();
    if (!WB_DATA_MEM_SELECT) return WB_JAL_SELECTED;
    case (WB_FUNC3)
      3'd0:    return 32'($signed(WB_DATA_OUT[7:0]));
      3'd1:    return 32'($signed(WB_DATA_OUT[15:0]));
      3'd4:    return 32'(WB_DATA_OUT[7:0]);
      3'd5:    return 32'(WB_DATA_OUT[15:0]);
      default: return WB_DATA_OUT;
    endcase
  endfunction

  // Model: what a read port must show for a given index right now.
  function automatic logic [31:0] m_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (RST && WB_WRITE_ENABLE && WB_RD != 5'd0 && WB_RD == addr) return m_result();
`endif
    return m_regs[addr];
  endfunction

  // Model state update on each commit edge.
  always @(posedge CLK) begin
    if (RST && WB_WRITE_ENABLE && WB_RD != 5'd0) begin
      m_regs[WB_RD] = m_result();
      m_count       = m_count + 32'd1;
    end
  end

  // Model asynchronous clear.
  always @(negedge RST) begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count = 32'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model each falling edge.
  always @(negedge CLK) begin
    if (cmp_on) begin
      check("cyc_rs1_data", RS1_DATA, m_read(RS1_ADDR));
      check("cyc_rs2_data", RS2_DATA, m_read(RS2_ADDR));
      check("cyc_wb_result", WB_RESULT, m_result());
      check("cyc_retire_count", RETIRE_COUNT, m_count);
    end
  end

  // Driver tasks.
  task automatic next_slot();
    @(negedge CLK);
    #2;
  endtask

  task automatic drive(input logic sel, input logic [2:0] f3, input logic [31:0] data,
                       input logic [31:0] jal, input logic [4:0] rd, input logic we,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    WB_DATA_MEM_SELECT = sel;
    WB_FUNC3           = f3;
    WB_DATA_OUT        = data;
    WB_JAL_SELECTED    = jal;
    WB_RD              = rd;
    WB_WRITE_ENABLE    = we;
    RS1_ADDR           = rs1;
    RS2_ADDR           = rs2;
  endtask

  // One committed writeback with a hand-computed expected value.
  task automatic vec(input string name, input logic sel, input logic [2:0] f3,
                     input logic [31:0] data, input logic [31:0] jal,
                     input logic [4:0] rd, input logic [31:0] exp);
    next_slot();
    drive(sel, f3, data, jal, rd, 1'b1, rd, 5'd0);
    #1;
    check({name, "_wb_result"}, WB_RESULT, exp);
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    check({name, "_stored"}, RS1_DATA, exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count = 32'd0;
    cmp_on  = 1'b0;
    RST     = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd5, 5'd7);
    #1;
    RST = 1'b0;
    #1;
    cmp_on = 1'b1;

    // Reset state and behaviour while held in reset.
    check("rst_rs1_x5", RS1_DATA, 32'd0);
    check("rst_rs2_x7", RS2_DATA, 32'd0);
    check("rst_count", RETIRE_COUNT, 32'd0);
    drive(1'b0, 3'd0, 32'd0, 32'h0000_0055, 5'd5, 1'b1, 5'd5, 5'd0);
    #1;
    check("rst_wb_result_live", WB_RESULT, 32'h0000_0055);
    @(posedge CLK);
    #1;
    check("rst_no_commit_x5", RS1_DATA, 32'd0);
    check("rst_no_commit_count", RETIRE_COUNT, 32'd0);
    next_slot();
    WB_WRITE_ENABLE = 1'b0;
    RST = 1'b1;

    // Load extension and writeback mux.
    vec("lb_neg",    1'b1, 3'b000, 32'h0000_00F0, 32'h0,          5'd5,  32'hFFFF_FFF0);
    vec("lbu",       1'b1, 3'b100, 32'h0000_00F0, 32'h0,          5'd5,  32'h0000_00F0);
    vec("lh_neg",    1'b1, 3'b001, 32'h0000_8001, 32'h0,          5'd5,  32'hFFFF_8001);
    vec("lhu",       1'b1, 3'b101, 32'h1234_F0F0, 32'h0,          5'd6,  32'h0000_F0F0);
    vec("lw",        1'b1, 3'b010, 32'h8000_0001, 32'h0,          5'd8,  32'h8000_0001);
    vec("f3_111",    1'b1, 3'b111, 32'h0000_FF80, 32'h0,          5'd9,  32'h0000_FF80);
    vec("lb_pos",    1'b1, 3'b000, 32'h0000_017F, 32'h0,          5'd10, 32'h0000_007F);
    vec("alu_path",  1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0080,  5'd11, 32'h0000_0080);
    check("count_after_8", RETIRE_COUNT, 32'd8);

    // x0 guard.
    next_slot();
    drive(1'b0, 3'd0, 32'd0, 32'hDEAD_BEEF, 5'd0, 1'b1, 5'd0, 5'd5);
    @(posedge CLK);
    #1;
    check("x0_reads_zero", RS1_DATA, 32'd0);
    check("x0_count_same", RETIRE_COUNT, 32'd8);
    check("x0_x5_kept", RS2_DATA, 32'hFFFF_8001);

    // Write enable low leaves everything alone.
    next_slot();
    drive(1'b0, 3'd0, 32'd0, 32'h0BAD_F00D, 5'd5, 1'b0, 5'd5, 5'd6);
    @(posedge CLK);
    #1;
    check("we0_x5_kept", RS1_DATA, 32'hFFFF_8001);
    check("we0_x6_kept", RS2_DATA, 32'h0000_F0F0);
    check("we0_count_same", RETIRE_COUNT, 32'd8);

    // Same-cycle read of the register being written.
    next_slot();
    drive(1'b0, 3'd0, 32'd0, 32'h1234_5678, 5'd7, 1'b1, 5'd7, 5'd7);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("byp_pre_rs1", RS1_DATA, 32'h1234_5678);
    check("byp_pre_rs2", RS2_DATA, 32'h1234_5678);
`else
    check("byp_pre_rs1", RS1_DATA, 32'h0000_0000);
    check("byp_pre_rs2", RS2_DATA, 32'h0000_0000);
`endif
    @(posedge CLK);
    #1;
    check("byp_post_rs1", RS1_DATA, 32'h1234_5678);
    check("byp_post_rs2", RS2_DATA, 32'h1234_5678);
    check("byp_count", RETIRE_COUNT, 32'd9);

    // Asynchronous reset in the middle of a run.
    next_slot();
    drive(1'b0, 3'd0, 32'd0, 32'hAAAA_5555, 5'd3, 1'b1, 5'd3, 5'd7);
    @(posedge CLK);
    #1;
    check("arst_x3_written", RS1_DATA, 32'hAAAA_5555);
    check("arst_count_10", RETIRE_COUNT, 32'd10);
    drive(1'b0, 3'd0, 32'd0, 32'h1111_1111, 5'd3, 1'b1, 5'd3, 5'd7);
    #2;
    RST = 1'b0;
    #1;
    check("arst_x3_cleared", RS1_DATA, 32'd0);
    check("arst_x7_cleared", RS2_DATA, 32'd0);
    check("arst_count_cleared", RETIRE_COUNT, 32'd0);
    check("arst_wb_result_live", WB_RESULT, 32'h1111_1111);
    @(posedge CLK);
    #1;
    check("arst_write_blocked", RS1_DATA, 32'd0);
    check("arst_count_blocked", RETIRE_COUNT, 32'd0);
    next_slot();
    WB_WRITE_ENABLE = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("arst_idle_x3", RS1_DATA, 32'd0);
    check("arst_idle_count", RETIRE_COUNT, 32'd0);

    // Retire counter wrap, preloaded to all ones.
    next_slot();
    force dut.retire_count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    check("wrap_preload", RETIRE_COUNT, 32'hFFFF_FFFF);
    drive(1'b0, 3'd0, 32'd0, 32'hCAFE_F00D, 5'd1, 1'b1, 5'd1, 5'd0);
    @(posedge CLK);
    #1;
    check("wrap_count_zero", RETIRE_COUNT, 32'd0);
    check("wrap_x1_written", RS1_DATA, 32'hCAFE_F00D);
    next_slot();
    drive(1'b0, 3'd0, 32'd0, 32'h0000_0042, 5'd31, 1'b1, 5'd31, 5'd1);
    @(posedge CLK);
    #1;
    check("post_wrap_count", RETIRE_COUNT, 32'd1);
    check("post_wrap_x31", RS1_DATA, 32'h0000_0042);

    next_slot();
    WB_WRITE_ENABLE = 1'b0;
    next_slot();
    next_slot();
    cmp_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL expose these ports (name direction width meaning), clock and reset first:
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset (0 = reset)
- WB_JAL_SELECTED  in  32  ALU/JAL result from MEM_WB
- WB_DATA_OUT  in  32  raw load data from MEM_WB, right-aligned
- WB_RD  in  5  destination register index
- WB_WRITE_ENABLE  in  1  register write request
- WB_DATA_MEM_SELECT  in  1  1 = load data, 0 = WB_JAL_SELECTED
- WB_FUNC3  in  3  load width/sign code
- RS1_ADDR, RS2_ADDR  in  5 each  decode-stage read indices
- RS1_DATA, RS2_DATA  out  32 each  read data, combinational
- WB_RESULT  out  32  final writeback value, combinational, for the forwarding unit
- RETIRE_COUNT  out  32  count of committed register writes

Function
REQ-002 Load extension, WB_FUNC3 when WB_DATA_MEM_SELECT=1: 000 sign-extend [7:0]; 001 sign-extend [15:0]; 010 full word; 100 zero-extend [7:0]; 101 zero-extend [15:0]; 011/110/111 full word.
REQ-003 WB_RESULT SHALL equal the extended load value when WB_DATA_MEM_SELECT=1, else WB_JAL_SELECTED; WB_FUNC3 is ignored when WB_DATA_MEM_SELECT=0.
REQ-004 Register file: 32 x 32-bit; x0 reads 0 always and is never written.
REQ-005 Commit: on rising CLK with RST=1, WB_WRITE_ENABLE=1, WB_RD!=0 -> reg[WB_RD] <= WB_RESULT; zero-cycle latency from MEM_WB output to storage.
REQ-006 Write with WB_RD=0 or WB_WRITE_ENABLE=0 SHALL leave all registers unchanged.
REQ-007 RS1_DATA/RS2_DATA SHALL be combinational from stored state (subject to REQ-014); both ports may address the same register.
REQ-008 RETIRE_COUNT increments by 1 on each commit per REQ-005; writes to x0 are not counted.
REQ-009 RETIRE_COUNT wraps 0xFFFFFFFF -> 0x00000000 without flag.
REQ-010 The block SHALL contain no stall or handshake: one commit opportunity per cycle, never back-pressured.

Reset
REQ-011 RST=0 SHALL immediately (no clock needed) clear all 31 writable registers and RETIRE_COUNT to 0.
REQ-012 While RST=0, commits SHALL be suppressed and RS1_DATA/RS2_DATA/WB_RESULT remain valid combinational functions (reads return 0).
REQ-013 Reset asserted mid-operation SHALL abort any pending write of that cycle; first commit possible on first rising CLK after RST returns to 1.

Configuration
REQ-014 Macro WB_REGFILE_BYPASS_EN: when defined, RSn_DATA SHALL return WB_RESULT whenever WB_WRITE_ENABLE=1, WB_RD!=0, WB_RD==RSn_ADDR and RST=1 (write-through same cycle); when undefined, RSn_DATA returns stored contents only, new value visible the cycle after the commit edge.
REQ-015 Macro SHALL NOT alter commit timing, RETIRE_COUNT, or x0 behaviour.

Verification
REQ-016 Load extension: SELECT=1, DATA_OUT=0x000000F0, FUNC3=000, RD=5, WE=1 -> after edge reg x5=0xFFFFFFF0; FUNC3=100 -> 0x000000F0; FUNC3=001 with 0x00008001 -> 0xFFFF8001.
REQ-017 x0 guard: WE=1, RD=0, JAL_SELECTED=0xDEADBEEF -> RS1_ADDR=0 reads 0, RETIRE_COUNT unchanged.
REQ-018 Bypass: WE=1, RD=7, SELECT=0, JAL_SELECTED=0x12345678, RS1_ADDR=RS2_ADDR=7, x7=0 -> before edge RS1_DATA=0x12345678 with WB_REGFILE_BYPASS_EN, 0x00000000 without; both 0x12345678 after edge.
REQ-019 Async reset mid-run: write x3=0xAAAA5555, then drop RST between edges -> x3 reads 0 and RETIRE_COUNT=0 before next edge; write presented during RST=0 not committed.
REQ-020 Counter wrap: preload by 2^32-1 commits (or force) -> next commit to RD=1 gives RETIRE_COUNT=0 and x1 updated.
